conv_kernel_ctrl: RTL and testbench

//  Kernel sequencer for the 5x5 RGB convolution filter. Holds preset kernels and scale divisors.

---
 rtl/conv_pkg.sv | 67 ++++++
 rtl/conv_kernel_ctrl_if.sv | 31 +++
 rtl/conv_kernel_rom.sv | 23 ++
 rtl/conv_kernel_ctrl.sv | 171 +++++++++++++++++
 tb/tb_conv_kernel_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared geometry, types and preset tables for the convolution kernel sequencer.
// CONV_CUSTOM_KERNEL_EN widens the preset ring by one writable kernel.
package conv_pkg;

    localparam int N           = 25;
    localparam int BW          = 8;
    localparam int WIDTH       = 320;
    localparam int HEIGHT      = 240;
    localparam int NUM_KERNELS = 4;
    localparam int TAP_W       = 5;

`ifdef CONV_CUSTOM_KERNEL_EN
    localparam int NUM_PRESETS = NUM_KERNELS + 1;
    localparam int IDX_W       = 3;
`else
    localparam int NUM_PRESETS = NUM_KERNELS;
    localparam int IDX_W       = 2;
`endif

    typedef logic signed [BW-1:0] coeff_t;
    typedef coeff_t               kernel_t [0:N-1];
    typedef logic [IDX_W-1:0]     idx_t;
    typedef enum logic [1:0] {IDLE, LOAD, ARMED, COMMIT} state_t;

    localparam kernel_t K_IDENTITY = '{
        8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0,
        8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0,
        8'sd0, 8'sd0, 8'sd1, 8'sd0, 8'sd0,
        8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0,
        8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};

    localparam kernel_t K_GAUSS3 = '{
        8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0,
        8'sd0, 8'sd1, 8'sd2, 8'sd1, 8'sd0,
        8'sd0, 8'sd2, 8'sd4, 8'sd2, 8'sd0,
        8'sd0, 8'sd1, 8'sd2, 8'sd1, 8'sd0,
        8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};

    // Taps sum to 331, matching the preset divisor.
    localparam kernel_t K_GAUSS5 = '{
        8'sd1, 8'sd4,  8'sd7,  8'sd4,  8'sd1,
        8'sd4, 8'sd20, 8'sd33, 8'sd20, 8'sd4,
        8'sd7, 8'sd33, 8'sd55, 8'sd33, 8'sd7,
        8'sd4, 8'sd20, 8'sd33, 8'sd20, 8'sd4,
        8'sd1, 8'sd4,  8'sd7,  8'sd4,  8'sd1};

    localparam kernel_t K_VEDGE = '{
        8'sd2, 8'sd1, 8'sd0, -8'sd1, -8'sd2,
        8'sd2, 8'sd1, 8'sd0, -8'sd1, -8'sd2,
        8'sd2, 8'sd1, 8'sd0, -8'sd1, -8'sd2,
        8'sd2, 8'sd1, 8'sd0, -8'sd1, -8'sd2,
        8'sd2, 8'sd1, 8'sd0, -8'sd1, -8'sd2};

    function automatic logic [15:0] preset_scale(input logic [1:0] sel);
        case (sel)
            2'd1:    return 16'd16;
            2'd2:    return 16'd331;
            default: return 16'd1;
        endcase
    endfunction

    function automatic idx_t step_idx(input idx_t cur, input logic up);
        if (up) return (cur == idx_t'(NUM_PRESETS - 1)) ? '0 : idx_t'(cur + 1'b1);
        return (cur == '0) ? idx_t'(NUM_PRESETS - 1) : idx_t'(cur - 1'b1);
    endfunction

endpackage

// File: rtl/conv_kernel_ctrl_if.sv
// Selection, pixel-monitor and coefficient bus between the sequencer and its neighbours.
// CONV_CUSTOM_KERNEL_EN adds the cfg write port for the RAM preset.
interface conv_kernel_ctrl_if;
    import conv_pkg::*;

    logic        sel_next;
    logic        sel_prev;
    logic        pix_valid;
    logic        pix_ready;
    kernel_t     h;
    logic [15:0] scale_down;
    idx_t        kernel_idx;
    logic        busy;

`ifdef CONV_CUSTOM_KERNEL_EN
    logic        cfg_wr;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_data;

    modport master (output sel_next, sel_prev, pix_valid, pix_ready, cfg_wr, cfg_addr, cfg_data,
                    input  h, scale_down, kernel_idx, busy);
    modport slave  (input  sel_next, sel_prev, pix_valid, pix_ready, cfg_wr, cfg_addr, cfg_data,
                    output h, scale_down, kernel_idx, busy);
`else
    modport master (output sel_next, sel_prev, pix_valid, pix_ready,
                    input  h, scale_down, kernel_idx, busy);
    modport slave  (input  sel_next, sel_prev, pix_valid, pix_ready,
                    output h, scale_down, kernel_idx, busy);
`endif

endinterface

// File: rtl/conv_kernel_rom.sv
// Combinational preset ROM: (kernel_sel, tap) -> coefficient, kernel_sel -> divisor.
module conv_kernel_rom
    import conv_pkg::*;
(
    input  logic [1:0]       kernel_sel,
    input  logic [TAP_W-1:0] tap,
    output coeff_t           coeff,
    output logic [15:0]      scale
);

    always_comb begin
        // NOTE: every output gets a default first, so no branch can leave one unassigned and infer a latch.
        coeff = '0;
        case (kernel_sel)
            2'd0:    coeff = K_IDENTITY[tap];
            2'd1:    coeff = K_GAUSS3[tap];
            2'd2:    coeff = K_GAUSS5[tap];
            default: coeff = K_VEDGE[tap];
        endcase
        scale = preset_scale(kernel_sel);
    end

endmodule

// File: rtl/conv_kernel_ctrl.sv
// Kernel sequencer: serially loads a preset into shadow regs and commits it at a frame boundary.
// CONV_CUSTOM_KERNEL_EN adds a cfg-written fifth preset (index 4) to the selection ring.
module conv_kernel_ctrl
    import conv_pkg::*;
#(
    parameter int WIDTH  = conv_pkg::WIDTH,
    parameter int HEIGHT = conv_pkg::HEIGHT
) (
    input  logic              clk,
    input  logic              reset,
    conv_kernel_ctrl_if.slave bus
);

    localparam int               FRAME_PIX = WIDTH * HEIGHT;
    localparam int               CNT_W     = $clog2(FRAME_PIX);
    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(FRAME_PIX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    idx_t             target_q, target_d;
    idx_t             pend_target_q, pend_target_d;
    idx_t             idx_q, idx_d;
    logic             pend_q, pend_d;
    kernel_t          shadow_q, shadow_d, h_q, h_d;
    logic [15:0]      shadow_scale_q, shadow_scale_d, scale_q, scale_d;

    coeff_t           rom_coeff, load_coeff;
    logic [15:0]      rom_scale, load_scale;
    logic             hs, frame_end, sel_one, sel_up;

    assign hs        = bus.pix_valid & bus.pix_ready;
    assign frame_end = hs && (cnt_q == LAST_PIX);
    assign sel_one   = bus.sel_next ^ bus.sel_prev;   // both at once is ignored
    assign sel_up    = bus.sel_next;

    conv_kernel_rom u_rom (
        .kernel_sel (target_q[1:0]),
        .tap        (tap_q),
        .coeff      (rom_coeff),
        .scale      (rom_scale)
    );

`ifdef CONV_CUSTOM_KERNEL_EN
    localparam idx_t CUSTOM_IDX = idx_t'(NUM_KERNELS);

    kernel_t     ram_q, ram_d;
    logic [15:0] ram_scale_q, ram_scale_d;

    always_comb begin
        ram_d       = ram_q;
        ram_scale_d = ram_scale_q;
        if (bus.cfg_wr && (state_q == IDLE)) begin
            if (bus.cfg_addr < TAP_W'(N))
                ram_d[bus.cfg_addr] = bus.cfg_data[BW-1:0];
            else if (bus.cfg_addr == TAP_W'(N))
                ram_scale_d = (bus.cfg_data == '0) ? 16'd1 : bus.cfg_data;
        end
    end

    always_ff @(posedge clk) ram_q <= ram_d;

    always_ff @(posedge clk) begin
        if (reset) ram_scale_q <= 16'd1;
        else       ram_scale_q <= ram_scale_d;
    end

    assign load_coeff = (target_q == CUSTOM_IDX) ? ram_q[tap_q] : rom_coeff;
    assign load_scale = (target_q == CUSTOM_IDX) ? ram_scale_q  : rom_scale;
`else
    assign load_coeff = rom_coeff;
    assign load_scale = rom_scale;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tap_d          = tap_q;
        target_d       = target_q;
        pend_d         = pend_q;
        pend_target_d  = pend_target_q;
        idx_d          = idx_q;
        shadow_d       = shadow_q;
        shadow_scale_d = shadow_scale_q;
        h_d            = h_q;
        scale_d        = scale_q;

        if (hs) cnt_d = (cnt_q == LAST_PIX) ? '0 : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (sel_one) begin
                    target_d = step_idx(idx_q, sel_up);
                    tap_d    = '0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                shadow_d[tap_q] = load_coeff;
                if (tap_q == '0) shadow_scale_d = load_scale;
                if (tap_q == TAP_W'(N - 1)) state_d = ARMED;
                else                        tap_d   = tap_q + 1'b1;
            end
            ARMED: begin
                if (frame_end) state_d = COMMIT;
            end
            COMMIT: begin
                h_d     = shadow_q;
                scale_d = shadow_scale_q;
                idx_d   = target_q;
                // A request landing in this very cycle is the latest one and goes straight to LOAD.
                if (sel_one) begin
                    target_d = step_idx(target_q, sel_up);
                    pend_d   = 1'b0;
                    tap_d    = '0;
                    state_d  = LOAD;
                end else if (pend_q) begin
                    target_d = pend_target_q;
                    pend_d   = 1'b0;
                    tap_d    = '0;
                    state_d  = LOAD;
                end else begin
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sel_one && ((state_q == LOAD) || (state_q == ARMED))) begin
            pend_d        = 1'b1;
            pend_target_d = step_idx(target_q, sel_up);
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tap_q         <= '0;
            target_q      <= '0;
            pend_q        <= 1'b0;
            pend_target_q <= '0;
            idx_q         <= '0;
            h_q           <= K_IDENTITY;
            scale_q       <= 16'd1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tap_q         <= tap_d;
            target_q      <= target_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
            idx_q         <= idx_d;
            h_q           <= h_d;
            scale_q       <= scale_d;
        end
    end

    // NOTE: shadow storage is not reset; LOAD rewrites every entry before COMMIT can read it.
    always_ff @(posedge clk) begin
        shadow_q       <= shadow_d;
        shadow_scale_q <= shadow_scale_d;
    end

    assign bus.h          = h_q;
    assign bus.scale_down = scale_q;
    assign bus.kernel_idx = idx_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_conv_kernel_ctrl.sv
// Directed bench for conv_kernel_ctrl on a shrunken 8x4 frame; commits are scored from a queue.
module tb_conv_kernel_ctrl;
    import conv_pkg::*;

    localparam int TB_W  = 8;
    localparam int TB_H  = 4;
    localparam int FRAME = TB_W * TB_H;
    localparam int HW    = N * BW;
`ifdef CONV_CUSTOM_KERNEL_EN
    localparam int NUM_P = 5;
`else
    localparam int NUM_P = 4;
`endif

    typedef struct {
        int           idx;
        logic [15:0]  scale;
        logic [HW-1:0] h;
    } exp_t;

    exp_t exp_q[$];
    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;
    int   pix_cnt    = 0;
    int   act_idx    = 0;

    conv_kernel_ctrl_if bus_if ();

    conv_kernel_ctrl #(.WIDTH(TB_W), .HEIGHT(TB_H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [HW-1:0] exp_kernel(input int k);
        int w3[5]  = '{0, 1, 2, 1, 0};
        int ew[5]  = '{2, 1, 0, -1, -2};
        int g5[25] = '{1, 4, 7, 4, 1,  4, 20, 33, 20, 4,  7, 33, 55, 33, 7,
                       4, 20, 33, 20, 4,  1, 4, 7, 4, 1};
        logic [HW-1:0] v;
        int c;
        v = '0;
        for (int t = 0; t < N; t++) begin
            case (k)
                0:       c = (t == 12) ? 1 : 0;
                1:       c = w3[t / 5] * w3[t % 5];
                2:       c = g5[t];
                3:       c = ew[t % 5];
                default: c = 1;
            endcase
            v[t*BW +: BW] = c[BW-1:0];
        end
        return v;
    endfunction

    function automatic logic [15:0] exp_scale(input int k);
        case (k)
            1:       return 16'd16;
            2:       return 16'd331;
            default: return 16'd1;
        endcase
    endfunction

    function automatic int exp_step(input int cur, input bit up);
        return up ? (cur + 1) % NUM_P : (cur + NUM_P - 1) % NUM_P;
    endfunction

    function automatic logic [HW-1:0] pack_h(input kernel_t k);
        logic [HW-1:0] v;
        for (int t = 0; t < N; t++) v[t*BW +: BW] = k[t];
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_h(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.idx   = k;
        e.scale = exp_scale(k);
        e.h     = exp_kernel(k);
        exp_q.push_back(e);
    endtask

    task automatic sb_compare(input string tag);
        exp_t e;
        compared++;
        assert (exp_q.size() != 0) else begin
            mismatched++;
            $error("FAIL %s_sb: observed empty queue expected an entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_idx"}, 32'(bus_if.kernel_idx), 32'(e.idx));
        check({tag, "_scale"}, 32'(bus_if.scale_down), 32'(e.scale));
        check_h({tag, "_h"}, pack_h(bus_if.h), e.h);
        act_idx = e.idx;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock with optional handshake and select pulses; idle cycles still toggle valid/ready singly.
    task automatic cyc(input logic hs_en, input logic nxt, input logic prv);
        bus_if.pix_valid = hs_en ? 1'b1 : pix_cnt[0];
        bus_if.pix_ready = hs_en ? 1'b1 : ~pix_cnt[0];
        bus_if.sel_next  = nxt;
        bus_if.sel_prev  = prv;
        step();
        if (hs_en) pix_cnt = (pix_cnt == FRAME - 1) ? 0 : pix_cnt + 1;
        bus_if.sel_next  = 1'b0;
        bus_if.sel_prev  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic advance_to(input int c);
        while (pix_cnt != c) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic commit_frame(input string tag);
        advance_to(FRAME - 1);
        cyc(1'b1, 1'b0, 1'b0);
        check_h({tag, "_hold_h"}, pack_h(bus_if.h), exp_kernel(act_idx));
        check({tag, "_hold_idx"}, 32'(bus_if.kernel_idx), 32'(act_idx));
        cyc(1'b0, 1'b0, 1'b0);
        sb_compare(tag);
    endtask

    // Frame end lands on the first ARMED cycle: commit must follow on the next edge.
    task automatic boundary_commit(input string tag, input bit up);
        advance_to(FRAME - 1 - N);
        push_exp(exp_step(act_idx, up));
        cyc(1'b0, up, ~up);
        repeat (N) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check_h({tag, "_hold_h"}, pack_h(bus_if.h), exp_kernel(act_idx));
        cyc(1'b0, 1'b0, 1'b0);
        sb_compare(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
        check({tag, "_idx"}, 32'(bus_if.kernel_idx), 32'd0);
        check({tag, "_scale"}, 32'(bus_if.scale_down), 32'd1);
        check_h({tag, "_h"}, pack_h(bus_if.h), exp_kernel(0));
    endtask

    initial begin
        reset            = 1'b1;
        bus_if.sel_next  = 1'b0;
        bus_if.sel_prev  = 1'b0;
        bus_if.pix_valid = 1'b0;
        bus_if.pix_ready = 1'b0;
`ifdef CONV_CUSTOM_KERNEL_EN
        bus_if.cfg_wr    = 1'b0;
        bus_if.cfg_addr  = '0;
        bus_if.cfg_data  = '0;
`endif
        step();
        step();
        check_reset_state("reset");
        reset = 1'b0;

`ifdef CONV_CUSTOM_KERNEL_EN
        for (int a = 0; a <= N; a++) begin
            bus_if.cfg_wr   = 1'b1;
            bus_if.cfg_addr = 5'(a);
            bus_if.cfg_data = (a < N) ? 16'h0001 : 16'h0000;
            step();
        end
        bus_if.cfg_wr = 1'b0;
        check("cfg_busy", 32'(bus_if.busy), 32'd0);
`endif

        // Frame end on the last LOAD cycle is ignored; commit waits one more frame.
        advance_to(FRAME - 1 - (N - 1));
        push_exp(exp_step(act_idx, 1'b1));
        cyc(1'b0, 1'b1, 1'b0);
        check("a_busy_load", 32'(bus_if.busy), 32'd1);
`ifdef CONV_CUSTOM_KERNEL_EN
        bus_if.cfg_wr   = 1'b1;
        bus_if.cfg_addr = 5'd0;
        bus_if.cfg_data = 16'h0005;
`endif
        repeat (N - 1) begin
            cyc(1'b1, 1'b0, 1'b0);
`ifdef CONV_CUSTOM_KERNEL_EN
            bus_if.cfg_wr = 1'b0;
`endif
        end
        cyc(1'b1, 1'b0, 1'b0);
        idle(3);
        check("a_busy_armed", 32'(bus_if.busy), 32'd1);
        check_h("a_h_unchanged", pack_h(bus_if.h), exp_kernel(0));
        commit_frame("a");
        check("a_busy_done", 32'(bus_if.busy), 32'd0);

        boundary_commit("b", 1'b0);

        push_exp(exp_step(act_idx, 1'b0));
        cyc(1'b0, 1'b0, 1'b1);
        idle(30);
        commit_frame("c");

        push_exp(exp_step(act_idx, 1'b1));
        cyc(1'b0, 1'b1, 1'b0);
        idle(30);
        commit_frame("d0");

        // Two requests during LOAD: pending target derives from the in-flight target.
        push_exp(exp_step(act_idx, 1'b1));
        cyc(1'b0, 1'b1, 1'b0);
        idle(3);
        cyc(1'b0, 1'b1, 1'b0);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0);
        push_exp(exp_step(exp_step(act_idx, 1'b1), 1'b1));
        idle(30);
        commit_frame("d1");
        check("d1_auto_load", 32'(bus_if.busy), 32'd1);
        idle(30);
        commit_frame("d2");
        check("d2_busy", 32'(bus_if.busy), 32'd0);

        cyc(1'b0, 1'b1, 1'b1);
        check("e_busy", 32'(bus_if.busy), 32'd0);
        idle(3);
        check("e_busy_later", 32'(bus_if.busy), 32'd0);
        advance_to(FRAME - 1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("e_idx", 32'(bus_if.kernel_idx), 32'(act_idx));
        check_h("e_h", pack_h(bus_if.h), exp_kernel(act_idx));

        // Reset mid-LOAD with a pending request and a non-zero pixel count.
        advance_to(10);
        cyc(1'b0, 1'b1, 1'b0);
        idle(3);
        cyc(1'b0, 1'b0, 1'b1);
        check("f_busy_pre", 32'(bus_if.busy), 32'd1);
        reset = 1'b1;
        step();
        check_reset_state("f_reset");
        reset   = 1'b0;
        pix_cnt = 0;
        act_idx = 0;
        exp_q.delete();
        advance_to(FRAME - 1);
        cyc(1'b1, 1'b0, 1'b0);
        idle(3);
        check("f_idle_busy", 32'(bus_if.busy), 32'd0);
        check("f_idle_idx", 32'(bus_if.kernel_idx), 32'd0);

        boundary_commit("g", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
